// File: rtl/obstacle_lane_engine_if.sv
// Control/status bundle between the game tick + input side and the obstacle lane engine.
interface obstacle_lane_engine_if #(
  parameter int N_OBST = 3
);
  logic                 iTick;
  logic                 iStart;
  logic                 iPause;
  logic [9:0]           iPlayerX;
  logic [N_OBST*10-1:0] oPosX;
  logic [N_OBST*9-1:0]  oPosY;
  logic [N_OBST-1:0]    oActive;
  logic [1:0]           oState;
  logic                 oScorePulse;
  logic                 oCrash;
  logic [2:0]           oSpeed;

  modport master (
    output iTick, iStart, iPause, iPlayerX,
    input  oPosX, oPosY, oActive, oState, oScorePulse, oCrash, oSpeed
  );
  modport slave (
    input  iTick, iStart, iPause, iPlayerX,
    output oPosX, oPosY, oActive, oState, oScorePulse, oCrash, oSpeed
  );
endinterface

// File: rtl/obstacle_lane_engine.sv
// Spawns, scrolls and retires falling obstacles across lanes; tracks level speed and
// detects overlap with the player box.
module obstacle_lane_engine #(
  parameter int N_OBST     = 3,
  parameter int LANES      = 4,
  parameter int LANE_X0    = 160,
  parameter int LANE_PITCH = 80,
  parameter int SCREEN_H   = 480,
  parameter int OBJ_W      = 40,
  parameter int OBJ_H      = 60,
  parameter int PLAYER_Y   = 400,
  parameter int SPAWN_GAP  = 160,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 7,
  parameter int LEVEL_PTS  = 8
) (
  input logic                   iClk,
  input logic                   iReset,
  obstacle_lane_engine_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] CRASH = 2'b11;
  localparam int DW = 11;

  logic [1:0]        stateReg, stateNext;
  logic [9:0]        posXReg [N_OBST];
  logic [8:0]        posYReg [N_OBST];
  logic [N_OBST-1:0] activeReg;
  logic [2:0]        speedReg, speedNext;
  logic [7:0]        levelCntReg, levelCntNext;
  logic [DW-1:0]     spawnDistReg, spawnDistNext;
  logic [7:0]        lfsrReg;
  logic              scorePulseReg, crashReg;

  logic              tickRun, clearAll, spawnOk, lfsrFb;
  logic [9:0]        movedY [N_OBST];
  logic [N_OBST-1:0] exitVec, hitVec, freeVec, spawnSel;
  logic [3:0]        exitCount;
  logic [9:0]        spawnX;
  logic [N_OBST*10-1:0] posXPacked;
  logic [N_OBST*9-1:0]  posYPacked;

  assign tickRun  = bus.iTick && (stateReg == RUN);
  assign clearAll = (stateReg == CRASH) && bus.iStart;
  assign lfsrFb   = lfsrReg[7] ^ lfsrReg[5] ^ lfsrReg[4] ^ lfsrReg[3];
  assign spawnX   = 10'(LANE_X0) + 10'(lfsrReg & 8'(LANES - 1)) * 10'(LANE_PITCH);

  // Overlap math is widened to 12 bits so edge sums never wrap.
  genvar gi;
  generate
    for (gi = 0; gi < N_OBST; gi++) begin : gSlot
      logic [11:0] obsX, plX, obsY;
      assign obsX        = {2'b00, posXReg[gi]};
      assign plX         = {2'b00, bus.iPlayerX};
      assign obsY        = {3'b000, posYReg[gi]};
      assign movedY[gi]  = {1'b0, posYReg[gi]} + {7'd0, speedReg};
      assign exitVec[gi] = activeReg[gi] && (movedY[gi] >= 10'(SCREEN_H));
      assign freeVec[gi] = !activeReg[gi] || exitVec[gi];
      assign hitVec[gi]  = activeReg[gi]
                           && (obsX < plX + 12'(OBJ_W)) && (plX < obsX + 12'(OBJ_W))
                           && (obsY < 12'(PLAYER_Y + OBJ_H)) && (12'(PLAYER_Y) < obsY + 12'(OBJ_H));
    end
  endgenerate

  assign spawnOk = (spawnDistReg >= DW'(SPAWN_GAP)) && (|freeVec);

  always_comb begin
    logic found;
    found      = 1'b0;
    spawnSel   = '0;
    exitCount  = '0;
    posXPacked = '0;
    posYPacked = '0;
    for (int i = 0; i < N_OBST; i++) begin
      if (freeVec[i] && !found) begin
        spawnSel[i] = 1'b1;
        found       = 1'b1;
      end
      exitCount = exitCount + 4'(exitVec[i]);
      posXPacked[10*i +: 10] = posXReg[i];
      posYPacked[9*i +: 9]   = posYReg[i];
    end
  end

  always_comb begin
    speedNext     = speedReg;
    levelCntNext  = levelCntReg;
    spawnDistNext = spawnDistReg;
    if (tickRun) begin
      levelCntNext = levelCntReg + 8'(exitCount);
      if (levelCntNext >= 8'(LEVEL_PTS)) begin
        levelCntNext = levelCntNext - 8'(LEVEL_PTS);
        if (speedReg < 3'(SPEED_MAX)) speedNext = speedReg + 3'd1;
      end
      if (spawnOk)
        spawnDistNext = '0;
      else if (spawnDistReg + DW'(speedReg) >= DW'(SPAWN_GAP))
        spawnDistNext = DW'(SPAWN_GAP);
      else
        spawnDistNext = spawnDistReg + DW'(speedReg);
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (bus.iStart) stateNext = RUN;
      RUN:     if (|hitVec) stateNext = CRASH;
               else if (bus.iPause) stateNext = PAUSE;
      PAUSE:   if (!bus.iPause) stateNext = RUN;
      default: if (bus.iStart) stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      stateReg      <= IDLE;
      activeReg     <= '0;
      speedReg      <= 3'(SPEED_INIT);
      levelCntReg   <= '0;
      spawnDistReg  <= DW'(SPAWN_GAP);
      lfsrReg       <= 8'hA5;
      scorePulseReg <= 1'b0;
      crashReg      <= 1'b0;
      for (int i = 0; i < N_OBST; i++) begin
        posXReg[i] <= 10'(LANE_X0);
        posYReg[i] <= '0;
      end
    end else begin
      stateReg      <= stateNext;
      crashReg      <= (stateNext == CRASH);
      lfsrReg       <= {lfsrReg[6:0], lfsrFb};
      scorePulseReg <= tickRun && (|exitVec);
      if (clearAll) begin
        activeReg    <= '0;
        speedReg     <= 3'(SPEED_INIT);
        levelCntReg  <= '0;
        spawnDistReg <= DW'(SPAWN_GAP);
        for (int i = 0; i < N_OBST; i++) begin
          posXReg[i] <= 10'(LANE_X0);
          posYReg[i] <= '0;
        end
      end else begin
        speedReg     <= speedNext;
        levelCntReg  <= levelCntNext;
        spawnDistReg <= spawnDistNext;
        // A slot retiring this tick may be reused immediately by the spawner.
        if (tickRun) begin
          for (int i = 0; i < N_OBST; i++) begin
            if (spawnOk && spawnSel[i]) begin
              activeReg[i] <= 1'b1;
              posYReg[i]   <= '0;
              posXReg[i]   <= spawnX;
            end else if (exitVec[i]) begin
              activeReg[i] <= 1'b0;
            end else if (activeReg[i]) begin
              posYReg[i] <= movedY[i][8:0];
            end
          end
        end
      end
    end
  end

  assign bus.oPosX       = posXPacked;
  assign bus.oPosY       = posYPacked;
  assign bus.oActive     = activeReg;
  assign bus.oState      = stateReg;
  assign bus.oScorePulse = scorePulseReg;
  assign bus.oCrash      = crashReg;
  assign bus.oSpeed      = speedReg;
endmodule
